// File: rtl/sodor_instr_sched_pkg.sv
// Shared types and constants for the sodor5 instruction-stream scheduler.
package sodor_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN,
        DONE
    } sched_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;

endpackage

// File: rtl/sodor_instr_sched_if.sv
// Requester handshakes and the core-side instruction slot of the scheduler.
interface sodor_instr_sched_if;

    logic        a_valid;
    logic [31:0] a_instr;
    logic        a_ready;
    logic        b_valid;
    logic [31:0] b_instr;
    logic        b_ready;
    logic        core_stall;
    logic [31:0] instr;
    logic        instr_valid;

    modport master (
        output a_valid, a_instr, b_valid, b_instr, core_stall,
        input  a_ready, b_ready, instr, instr_valid
    );

    modport slave (
        input  a_valid, a_instr, b_valid, b_instr, core_stall,
        output a_ready, b_ready, instr, instr_valid
    );

endinterface

// File: rtl/sodor_instr_sched_arb.sv
// Two-requester round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module sodor_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    // ptr_q == 0 favours A on a tie; it always points away from the last grant.
    logic ptr_q, ptr_d;

    always_comb begin
        grant_o = 2'b00;
        ptr_d   = ptr_q;
        if (en_i) begin
            if (valid_i == 2'b11) begin
                grant_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant_o = valid_i;
            end
            if (grant_o[0]) begin
                ptr_d = 1'b1;
            end else if (grant_o[1]) begin
                ptr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sodor_instr_sched.sv
// Schedules requesters A/B into the core's single instruction slot, with init
// hold-off, NOP bubbles and a pipeline-flushing drain at the end of each run.
module sodor_instr_sched
    import sodor_sched_pkg::*;
#(
    parameter int INIT_CYCLES = 3,
    parameter int DRAIN_NOPS  = 5,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     run_len,
    sodor_instr_sched_if.slave   bus,
    output logic                 core_reset,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     issued_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam int INIT_W  = $clog2(INIT_CYCLES + 1);
    localparam int DRAIN_W = $clog2(DRAIN_NOPS + 1);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] issued_inc;
    logic [INIT_W-1:0]  init_q, init_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [31:0]      instr_q, instr_d;
    logic             vld_q, vld_d;
    logic             arb_en;
    logic [1:0]       grant;

    assign arb_en     = (state_q == RUN) && !bus.core_stall;
    assign issued_inc = issued_q + 1'b1;

    sodor_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid_i ({bus.b_valid, bus.a_valid}),
        .en_i    (arb_en),
        .grant_o (grant)
    );

    assign bus.a_ready     = grant[0];
    assign bus.b_ready     = grant[1];
    assign bus.instr       = instr_q;
    assign bus.instr_valid = vld_q;
    assign core_reset      = (state_q == IDLE) || (state_q == INIT);
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign issued_cnt      = issued_q;
    assign bubble_cnt      = bubble_q;

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        issued_d  = issued_q;
        bubble_d  = bubble_q;
        init_d    = init_q;
        drain_d   = drain_q;
        instr_d   = instr_q;
        vld_d     = vld_q;
        case (state_q)
            IDLE: begin
                instr_d = NOP_INSTR;
                vld_d   = 1'b0;
                if (start) begin
                    run_len_d = run_len;
                    issued_d  = '0;
                    bubble_d  = '0;
                    init_d    = '0;
                    drain_d   = '0;
                    state_d   = INIT;
                end
            end
            INIT: begin
                instr_d = NOP_INSTR;
                vld_d   = 1'b0;
                if (init_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d = (run_len_q == '0) ? DRAIN : RUN;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end
            RUN: begin
                if (!bus.core_stall) begin
                    vld_d = 1'b1;
                    if (grant[0]) begin
                        instr_d  = bus.a_instr;
                        issued_d = issued_inc;
                    end else if (grant[1]) begin
                        instr_d  = bus.b_instr;
                        issued_d = issued_inc;
                    end else begin
                        instr_d = NOP_INSTR;
                        if (bubble_q != '1) begin
                            bubble_d = bubble_q + 1'b1;
                        end
                    end
                    if ((grant != 2'b00) && (issued_inc == run_len_q)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The final drain NOP stays on the slot until the core takes it.
                if (!bus.core_stall) begin
                    instr_d = NOP_INSTR;
                    if (drain_q == DRAIN_W'(DRAIN_NOPS)) begin
                        vld_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        vld_d   = 1'b1;
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            DONE: begin
                instr_d = NOP_INSTR;
                vld_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            issued_q <= '0;
            bubble_q <= '0;
            init_q   <= '0;
            drain_q  <= '0;
            instr_q  <= NOP_INSTR;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            bubble_q <= bubble_d;
            init_q   <= init_d;
            drain_q  <= drain_d;
            instr_q  <= instr_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        run_len_q <= run_len_d;
    end

endmodule

// File: tb/tb_sodor_instr_sched.sv
// Scoreboard bench for sodor_instr_sched: expected issue streams are queued per scenario.
module tb_sodor_instr_sched;
    import sodor_sched_pkg::*;

    localparam int INIT_CYCLES = 3;
    localparam int DRAIN_NOPS  = 5;
    localparam int CNT_W       = 16;

    localparam logic [31:0] W_A1 = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, OPC_RTYPE}; // 0x002081B3
    localparam logic [31:0] W_A2 = 32'h00A0_0033;
    localparam logic [31:0] W_B2 = 32'h00B0_0033;
    localparam logic [31:0] W_LD = {12'd0, 5'd1, 3'b010, 5'd5, OPC_LOAD};      // lw x5,0(x1)

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] run_len = '0;
    logic             core_reset, busy, done;
    logic [CNT_W-1:0] issued_cnt, bubble_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    sodor_instr_sched_if ifc();

    sodor_instr_sched #(
        .INIT_CYCLES (INIT_CYCLES),
        .DRAIN_NOPS  (DRAIN_NOPS),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .run_len    (run_len),
        .bus        (ifc),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .issued_cnt (issued_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic int exp_done_n(input int run_cycles);
        return INIT_CYCLES + run_cycles + DRAIN_NOPS + 2;
    endfunction

    task automatic push_words(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(w);
    endtask

    // Called at a negedge; returns at the negedge of the first INIT cycle.
    task automatic start_run(input logic [CNT_W-1:0] len);
        run_len = len;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        run_len = 16'd1;
    endtask

    // Steps a run from the first INIT cycle (n=1) until done, popping the scoreboard
    // on every newly loaded valid word and checking stall hold and ready rules.
    task automatic wait_done(input string tag, input int budget, input int a_on,
                             input int stall_from, input int stall_len,
                             output int done_n, output int run_n, output int na, output int nb);
        logic             prev_stall, prev_vld;
        logic [31:0]      prev_instr, exp_w;
        logic [CNT_W-1:0] prev_iss, prev_bub;
        int n;
        done_n = 0; run_n = 0; na = 0; nb = 0;
        prev_stall = 1'b0; prev_vld = 1'b0; prev_instr = '0; prev_iss = '0; prev_bub = '0;
        n = 1;
        while (done_n == 0 && n <= budget) begin
            if (ifc.instr_valid === 1'b1 && !prev_stall) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s issue@%0d: got extra word %h, required no word", tag, n, ifc.instr);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (ifc.instr !== exp_w) begin
                        errors++;
                        $display("FAIL %s issue@%0d: got %h, required %h", tag, n, ifc.instr, exp_w);
                    end
                end
            end
            if (prev_stall) begin
                checks++;
                if ({ifc.instr, ifc.instr_valid, issued_cnt, bubble_cnt} !==
                    {prev_instr, prev_vld, prev_iss, prev_bub}) begin
                    errors++;
                    $display("FAIL %s stall_hold@%0d: got %h/%b/%0d/%0d, required %h/%b/%0d/%0d", tag, n,
                             ifc.instr, ifc.instr_valid, issued_cnt, bubble_cnt,
                             prev_instr, prev_vld, prev_iss, prev_bub);
                end
            end
            if (run_n == 0 && core_reset === 1'b0) run_n = n;
            if (done === 1'b1) begin
                done_n = n;
                checks++;
                if (ifc.instr_valid !== 1'b0 || ifc.instr !== NOP_INSTR) begin
                    errors++;
                    $display("FAIL %s done_slot: got %h/%b, required %h/0", tag, ifc.instr, ifc.instr_valid, NOP_INSTR);
                end
            end else begin
                ifc.a_valid    = (n >= a_on);
                ifc.core_stall = (n >= stall_from) && (n < stall_from + stall_len);
                #1;
                checks++;
                if ((ifc.a_ready === 1'b1 && ifc.b_ready === 1'b1) ||
                    ((core_reset === 1'b1 || ifc.core_stall) && (ifc.a_ready !== 1'b0 || ifc.b_ready !== 1'b0))) begin
                    errors++;
                    $display("FAIL %s ready@%0d: got a=%b b=%b (core_reset=%b stall=%b), required no illegal grant",
                             tag, n, ifc.a_ready, ifc.b_ready, core_reset, ifc.core_stall);
                end
                if (ifc.a_ready === 1'b1) na++;
                if (ifc.b_ready === 1'b1) nb++;
                prev_stall = ifc.core_stall; prev_vld = ifc.instr_valid; prev_instr = ifc.instr;
                prev_iss = issued_cnt; prev_bub = bubble_cnt;
                @(negedge clk);
                n++;
            end
        end
        ifc.core_stall = 1'b0;
        checks++;
        if (done_n == 0) begin
            errors++;
            $display("FAIL %s timeout: got no done in %0d cycles, required a done pulse", tag, budget);
        end
    endtask

    // Checks the cycle after done, the final counters and that the scoreboard emptied.
    task automatic check_end(input string tag, input int done_n, input int exp_dn,
                             input int iss, input int bub);
        checks++;
        if (done_n != exp_dn) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, required %0d", tag, done_n, exp_dn);
        end
        checks++;
        if (issued_cnt !== CNT_W'(iss) || bubble_cnt !== CNT_W'(bub)) begin
            errors++;
            $display("FAIL %s counters: got %0d/%0d, required %0d/%0d", tag, issued_cnt, bubble_cnt, iss, bub);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s scoreboard: got %0d words left, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || core_reset !== 1'b1 || ifc.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b core_reset=%b vld=%b, required 0/0/1/0",
                     tag, done, busy, core_reset, ifc.instr_valid);
        end
        checks++;
        if (issued_cnt !== CNT_W'(iss) || bubble_cnt !== CNT_W'(bub)) begin
            errors++;
            $display("FAIL %s counters_hold: got %0d/%0d, required %0d/%0d", tag, issued_cnt, bubble_cnt, iss, bub);
        end
    endtask

    task automatic test_reset();
        ifc.a_valid = 1'b1; ifc.a_instr = W_A1; ifc.b_valid = 1'b1; ifc.b_instr = W_B2;
        ifc.core_stall = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ifc.instr !== NOP_INSTR || ifc.instr_valid !== 1'b0 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_slot: got %h/%b/%b, required %h/0/1", ifc.instr, ifc.instr_valid, core_reset, NOP_INSTR);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || issued_cnt !== '0 || bubble_cnt !== '0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b cnt=%0d/%0d, required 0/0/0/0", busy, done, issued_cnt, bubble_cnt);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ifc.a_ready !== 1'b0 || ifc.b_ready !== 1'b0 || busy !== 1'b0 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got a=%b b=%b busy=%b core_reset=%b, required 0/0/0/1",
                     ifc.a_ready, ifc.b_ready, busy, core_reset);
        end
        ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
    endtask

    task automatic test_alternate();
        int dn, rn, na, nb;
        ifc.a_instr = W_A2; ifc.b_instr = W_B2; ifc.b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(W_A2);
            exp_q.push_back(W_B2);
        end
        push_words(NOP_INSTR, DRAIN_NOPS);
        start_run(16'd6);
        wait_done("alternate", 60, 1, 0, 0, dn, rn, na, nb);
        checks++;
        if (na != 3 || nb != 3) begin
            errors++;
            $display("FAIL alternate_readies: got a=%0d b=%0d, required 3/3", na, nb);
        end
        check_end("alternate", dn, exp_done_n(6), 6, 0);
        ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
    endtask

    task automatic test_single_a();
        int dn, rn, na, nb;
        ifc.a_instr = W_A1; ifc.a_valid = 1'b1; ifc.b_valid = 1'b0;
        push_words(W_A1, 4);
        push_words(NOP_INSTR, DRAIN_NOPS);
        start_run(16'd4);
        checks++;
        if (busy !== 1'b1 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL single_init: got busy=%b core_reset=%b, required 1/1", busy, core_reset);
        end
        wait_done("single_a", 60, 1, 0, 0, dn, rn, na, nb);
        checks++;
        if (rn != INIT_CYCLES + 1) begin
            errors++;
            $display("FAIL single_core_reset: got release at cycle %0d, required %0d", rn, INIT_CYCLES + 1);
        end
        checks++;
        if (na != 4 || nb != 0) begin
            errors++;
            $display("FAIL single_readies: got a=%0d b=%0d, required 4/0", na, nb);
        end
        check_end("single_a", dn, exp_done_n(4), 4, 0);
        ifc.a_valid = 1'b0;
    endtask

    task automatic test_bubbles();
        int dn, rn, na, nb;
        ifc.a_instr = W_LD; ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
        push_words(NOP_INSTR, 2);
        push_words(W_LD, 3);
        push_words(NOP_INSTR, DRAIN_NOPS);
        start_run(16'd3);
        wait_done("bubbles", 60, INIT_CYCLES + 3, 0, 0, dn, rn, na, nb);
        checks++;
        if (na != 3) begin
            errors++;
            $display("FAIL bubbles_readies: got a=%0d, required 3", na);
        end
        check_end("bubbles", dn, exp_done_n(5), 3, 2);
        ifc.a_valid = 1'b0;
    endtask

    task automatic test_stall();
        int dn, rn, na, nb;
        ifc.a_instr = W_A2; ifc.a_valid = 1'b1; ifc.b_valid = 1'b0;
        push_words(W_A2, 5);
        push_words(NOP_INSTR, DRAIN_NOPS);
        start_run(16'd5);
        wait_done("stall", 60, 1, INIT_CYCLES + 2, 3, dn, rn, na, nb);
        checks++;
        if (na != 5) begin
            errors++;
            $display("FAIL stall_readies: got a=%0d, required 5", na);
        end
        check_end("stall", dn, exp_done_n(5) + 3, 5, 0);
        ifc.a_valid = 1'b0;
    endtask

    task automatic test_zero_len();
        int dn, rn, na, nb;
        ifc.a_instr = W_A1; ifc.b_instr = W_B2; ifc.a_valid = 1'b1; ifc.b_valid = 1'b1;
        push_words(NOP_INSTR, DRAIN_NOPS);
        start_run(16'd0);
        wait_done("zero_len", 40, 1, 0, 0, dn, rn, na, nb);
        checks++;
        if (na != 0 || nb != 0) begin
            errors++;
            $display("FAIL zero_len_readies: got a=%0d b=%0d, required 0/0", na, nb);
        end
        check_end("zero_len", dn, exp_done_n(0), 0, 0);
        ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
    endtask

    task automatic test_abort();
        int saw_done;
        saw_done = 0;
        ifc.a_instr = W_A1; ifc.a_valid = 1'b1; ifc.b_valid = 1'b0;
        start_run(16'd4);
        for (int n = 1; n < 9; n++) begin
            if (n == INIT_CYCLES + 2) begin
                start = 1'b1; run_len = 16'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) saw_done++;
            if (n == INIT_CYCLES + 2) begin
                checks++;
                if (core_reset !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_start_ignored: got core_reset=%b busy=%b, required 0/1", core_reset, busy);
                end
            end
        end
        checks++;
        if (issued_cnt !== 16'd4 || busy !== 1'b1 || ifc.instr !== NOP_INSTR || ifc.instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_drain: got cnt=%0d busy=%b instr=%h vld=%b, required 4/1/%h/1",
                     issued_cnt, busy, ifc.instr, ifc.instr_valid, NOP_INSTR);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ifc.instr !== NOP_INSTR || ifc.instr_valid !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b0 ||
            issued_cnt !== '0 || bubble_cnt !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got %h/%b core_reset=%b busy=%b cnt=%0d/%0d done=%b, required %h/0 1 0 0/0 0",
                     ifc.instr, ifc.instr_valid, core_reset, busy, issued_cnt, bubble_cnt, done, NOP_INSTR);
        end
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) saw_done++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) saw_done++;
        end
        checks++;
        if (saw_done != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done cycles busy=%b, required 0/0", saw_done, busy);
        end
        ifc.a_valid = 1'b0;
    endtask

    initial begin
        ifc.a_valid = 1'b0; ifc.a_instr = '0; ifc.b_valid = 1'b0; ifc.b_instr = '0;
        ifc.core_stall = 1'b0;
        test_reset();
        test_alternate();
        test_single_a();
        test_bubbles();
        test_stall();
        test_zero_len();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
